// File: rtl/pc_redirect_ctrl_if.sv
// rtl/pc_redirect_ctrl_if.sv - EX-to-front-end redirect/stall control bundle
//
// Purpose: groups the branch-resolution inputs, the hazard/stall inputs and the
//          PC/pipeline-register control outputs of pc_redirect_ctrl.
// Ports (signals):
//   ex_valid, branch_ctrl[1:0], alu_target, imm_target   branch decision from EX
//   imem_stall, dmem_stall, load_use                     stall / hazard sources
//   redirect_valid, redirect_pc                          PC mux control
//   pc_write, ifid_write, ifid_flush, idex_flush         pipeline register control
//   hold_pending, redirect_cnt                           status / perf counter
// Modports: master = EX/hazard side (drives requests), slave = the controller.

interface pc_redirect_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             ex_valid;
    logic [1:0]       branch_ctrl;
    logic [XLEN-1:0]  alu_target;
    logic [XLEN-1:0]  imm_target;
    logic             imem_stall;
    logic             dmem_stall;
    logic             load_use;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             hold_pending;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        output ex_valid, branch_ctrl, alu_target, imm_target,
               imem_stall, dmem_stall, load_use,
        input  redirect_valid, redirect_pc, pc_write, ifid_write,
               ifid_flush, idex_flush, hold_pending, redirect_cnt
    );

    modport slave (
        input  ex_valid, branch_ctrl, alu_target, imm_target,
               imem_stall, dmem_stall, load_use,
        output redirect_valid, redirect_pc, pc_write, ifid_write,
               ifid_flush, idex_flush, hold_pending, redirect_cnt
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - PC redirect, flush and stall sequencer for a 5-stage core
//
// Purpose: turns the resolved EX branch decision into a same-cycle PC redirect plus
//          IF/ID and ID/EX flushes, folds in load-use and memory stalls, parks a
//          redirect that resolves while instruction fetch is stalled (HOLD) and
//          replays it once fetch is ready. Counts redirect cycles (saturating).
// Ports:
//   clk   clock
//   rst   asynchronous active-low reset
//   bus   pc_redirect_ctrl_if.slave (branch inputs, stalls, pipeline controls)

module pc_redirect_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    pc_redirect_ctrl_if.slave   bus
);
    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [XLEN-1:0]    pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               req;
    logic [XLEN-1:0]    tgt;
    logic               redirect_valid_c;
    logic [XLEN-1:0]    redirect_pc_c;
    logic               pc_write_c;
    logic               ifid_write_c;
    logic               ifid_flush_c;
    logic               idex_flush_c;

    // branch_ctrl==3 is reserved and treated as sequential.
    assign req = bus.ex_valid && (bus.branch_ctrl == 2'd1 || bus.branch_ctrl == 2'd2);
    assign tgt = (bus.branch_ctrl == 2'd1) ? bus.alu_target : bus.imm_target;

    always_comb begin
        redirect_valid_c = 1'b0;
        redirect_pc_c    = tgt;
        pc_write_c       = 1'b1;
        ifid_write_c     = 1'b1;
        ifid_flush_c     = 1'b0;
        idex_flush_c     = 1'b0;
        state_d          = state_q;
        pend_pc_d        = pend_pc_q;

        if (bus.dmem_stall) begin
            // Whole pipeline frozen: nothing moves, nothing is flushed.
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
        end else if (state_q == HOLD) begin
            // EX content is ignored here; the parked target is the only authority.
            if (bus.imem_stall) begin
                pc_write_c   = 1'b0;
                ifid_write_c = 1'b0;
                idex_flush_c = 1'b1;
            end else begin
                redirect_valid_c = 1'b1;
                redirect_pc_c    = pend_pc_q;
                ifid_flush_c     = 1'b1;
                idex_flush_c     = 1'b1;
                state_d          = RUN;
            end
        end else if (req && !bus.imem_stall) begin
            redirect_valid_c = 1'b1;
            ifid_flush_c     = 1'b1;
            idex_flush_c     = 1'b1;
        end else if (req) begin
            // Fetch cannot accept the new PC yet: park it and bubble EX.
            pend_pc_d    = tgt;
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            idex_flush_c = 1'b1;
            state_d      = HOLD;
        end else if (bus.load_use || bus.imem_stall) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            idex_flush_c = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (redirect_valid_c && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            pend_pc_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    // Outputs are forced low for as long as reset is held.
    assign bus.redirect_valid = rst && redirect_valid_c;
    assign bus.redirect_pc    = rst ? redirect_pc_c : '0;
    assign bus.pc_write       = rst && pc_write_c;
    assign bus.ifid_write     = rst && ifid_write_c;
    assign bus.ifid_flush     = rst && ifid_flush_c;
    assign bus.idex_flush     = rst && idex_flush_c;
    assign bus.hold_pending   = rst && (state_q == HOLD);
    assign bus.redirect_cnt   = rst ? cnt_q : '0;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - directed self-checking bench for pc_redirect_ctrl

module tb_pc_redirect_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [15:0] exp_cnt;

    pc_redirect_ctrl_if #(.XLEN(32), .CNT_W(16)) bus ();

    pc_redirect_ctrl #(.XLEN(32), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // {redirect_valid, pc_write, ifid_write, ifid_flush, idex_flush, hold_pending}
    wire [5:0] ctl = {bus.redirect_valid, bus.pc_write, bus.ifid_write,
                      bus.ifid_flush, bus.idex_flush, bus.hold_pending};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst === 1'b1 && bus.ex_valid === 1'b1)
            assert (!$isunknown(bus.branch_ctrl)) else $error("branch_ctrl unknown while ex_valid");
    end

    task automatic set_idle();
        bus.ex_valid    = 1'b0;
        bus.branch_ctrl = 2'd0;
        bus.alu_target  = 32'h0;
        bus.imm_target  = 32'h0;
        bus.imem_stall  = 1'b0;
        bus.dmem_stall  = 1'b0;
        bus.load_use    = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            bus.ex_valid    = 1'($urandom);
            bus.branch_ctrl = 2'($urandom);
            bus.alu_target  = $urandom;
            bus.imm_target  = $urandom;
            bus.imem_stall  = 1'($urandom);
            bus.dmem_stall  = 1'($urandom);
            bus.load_use    = 1'($urandom);
            @(negedge clk);
            total++; if (ctl !== 6'b000000) begin bad++; $display("FAIL rst_ctl got=%b exp=%b", ctl, 6'b000000); end
            total++; if (bus.redirect_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=%h", bus.redirect_pc, 32'h0); end
            total++; if (bus.redirect_cnt !== 16'h0) begin bad++; $display("FAIL rst_cnt got=%h exp=%h", bus.redirect_cnt, 16'h0); end
        end
        next_cycle();
        set_idle();
        rst = 1'b1;
        exp_cnt = 16'h0;
        @(negedge clk);
        total++; if (ctl !== 6'b011000) begin bad++; $display("FAIL rel_ctl got=%b exp=%b", ctl, 6'b011000); end
        total++; if (bus.redirect_cnt !== 16'h0) begin bad++; $display("FAIL rel_cnt got=%h exp=%h", bus.redirect_cnt, 16'h0); end
    endtask

    task automatic test_redirect_imm();
        next_cycle();
        bus.ex_valid = 1'b1; bus.branch_ctrl = 2'd2; bus.imm_target = 32'h100; bus.alu_target = 32'h55;
        @(negedge clk);
        total++; if (ctl !== 6'b111110) begin bad++; $display("FAIL imm_ctl got=%b exp=%b", ctl, 6'b111110); end
        total++; if (bus.redirect_pc !== 32'h100) begin bad++; $display("FAIL imm_pc got=%h exp=%h", bus.redirect_pc, 32'h100); end
        next_cycle();
        set_idle();
        exp_cnt = 16'd1;
        total++; if (bus.redirect_cnt !== exp_cnt) begin bad++; $display("FAIL imm_cnt got=%h exp=%h", bus.redirect_cnt, exp_cnt); end
    endtask

    task automatic test_hold_replay();
        bus.ex_valid = 1'b1; bus.branch_ctrl = 2'd1; bus.alu_target = 32'h2A4; bus.imm_target = 32'h7777; bus.imem_stall = 1'b1;
        @(negedge clk);
        total++; if (ctl !== 6'b000010) begin bad++; $display("FAIL hold_enter_ctl got=%b exp=%b", ctl, 6'b000010); end
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            // EX now shows a different branch; HOLD must ignore it.
            bus.alu_target = 32'hDEAD0000 + i;
            @(negedge clk);
            total++; if (ctl !== 6'b000011) begin bad++; $display("FAIL hold_wait_ctl%0d got=%b exp=%b", i, ctl, 6'b000011); end
        end
        next_cycle();
        set_idle();
        bus.imm_target = 32'h1234;
        @(negedge clk);
        total++; if (ctl !== 6'b111111) begin bad++; $display("FAIL replay_ctl got=%b exp=%b", ctl, 6'b111111); end
        total++; if (bus.redirect_pc !== 32'h2A4) begin bad++; $display("FAIL replay_pc got=%h exp=%h", bus.redirect_pc, 32'h2A4); end
        next_cycle();
        exp_cnt = 16'd2;
        @(negedge clk);
        total++; if (ctl !== 6'b011000) begin bad++; $display("FAIL replay_after_ctl got=%b exp=%b", ctl, 6'b011000); end
        total++; if (bus.redirect_cnt !== exp_cnt) begin bad++; $display("FAIL replay_cnt got=%h exp=%h", bus.redirect_cnt, exp_cnt); end
    endtask

    task automatic test_dmem_stall();
        next_cycle();
        bus.ex_valid = 1'b1; bus.branch_ctrl = 2'd2; bus.imm_target = 32'h440; bus.dmem_stall = 1'b1;
        @(negedge clk);
        total++; if (ctl !== 6'b000000) begin bad++; $display("FAIL dmem_ctl got=%b exp=%b", ctl, 6'b000000); end
        next_cycle();
        total++; if (bus.redirect_cnt !== exp_cnt) begin bad++; $display("FAIL dmem_cnt got=%h exp=%h", bus.redirect_cnt, exp_cnt); end
        bus.dmem_stall = 1'b0;
        @(negedge clk);
        total++; if (ctl !== 6'b111110) begin bad++; $display("FAIL dmem_rel_ctl got=%b exp=%b", ctl, 6'b111110); end
        total++; if (bus.redirect_pc !== 32'h440) begin bad++; $display("FAIL dmem_rel_pc got=%h exp=%h", bus.redirect_pc, 32'h440); end
        next_cycle();
        set_idle();
        exp_cnt = 16'd3;
        total++; if (bus.redirect_cnt !== exp_cnt) begin bad++; $display("FAIL dmem_rel_cnt got=%h exp=%h", bus.redirect_cnt, exp_cnt); end
        // dmem_stall while parked in HOLD keeps the pending redirect parked.
        bus.ex_valid = 1'b1; bus.branch_ctrl = 2'd1; bus.alu_target = 32'h880; bus.imem_stall = 1'b1;
        next_cycle();
        set_idle();
        bus.dmem_stall = 1'b1;
        @(negedge clk);
        total++; if (ctl !== 6'b000001) begin bad++; $display("FAIL dmem_hold_ctl got=%b exp=%b", ctl, 6'b000001); end
        next_cycle();
        bus.dmem_stall = 1'b0;
        @(negedge clk);
        total++; if (ctl !== 6'b111111) begin bad++; $display("FAIL dmem_hold_rel_ctl got=%b exp=%b", ctl, 6'b111111); end
        total++; if (bus.redirect_pc !== 32'h880) begin bad++; $display("FAIL dmem_hold_rel_pc got=%h exp=%h", bus.redirect_pc, 32'h880); end
        next_cycle();
        exp_cnt = 16'd4;
    endtask

    task automatic test_load_use();
        bus.ex_valid = 1'b1; bus.branch_ctrl = 2'd1; bus.alu_target = 32'h9C0; bus.load_use = 1'b1;
        @(negedge clk);
        total++; if (ctl !== 6'b111110) begin bad++; $display("FAIL lu_req_ctl got=%b exp=%b", ctl, 6'b111110); end
        total++; if (bus.redirect_pc !== 32'h9C0) begin bad++; $display("FAIL lu_req_pc got=%h exp=%h", bus.redirect_pc, 32'h9C0); end
        next_cycle();
        exp_cnt = 16'd5;
        bus.ex_valid = 1'b0;
        @(negedge clk);
        total++; if (ctl !== 6'b000010) begin bad++; $display("FAIL lu_only_ctl got=%b exp=%b", ctl, 6'b000010); end
        next_cycle();
        // Reserved encoding and a bubble in EX must not redirect.
        set_idle();
        bus.ex_valid = 1'b1; bus.branch_ctrl = 2'd3;
        @(negedge clk);
        total++; if (ctl !== 6'b011000) begin bad++; $display("FAIL bc3_ctl got=%b exp=%b", ctl, 6'b011000); end
        next_cycle();
        bus.ex_valid = 1'b0; bus.branch_ctrl = 2'd1;
        @(negedge clk);
        total++; if (ctl !== 6'b011000) begin bad++; $display("FAIL bubble_ctl got=%b exp=%b", ctl, 6'b011000); end
        next_cycle();
        set_idle();
        total++; if (bus.redirect_cnt !== exp_cnt) begin bad++; $display("FAIL lu_cnt got=%h exp=%h", bus.redirect_cnt, exp_cnt); end
    endtask

    task automatic test_saturate_and_reset_in_hold();
        bus.ex_valid = 1'b1; bus.branch_ctrl = 2'd2; bus.imm_target = 32'h40;
        repeat (int'(16'hFFFF - exp_cnt)) @(posedge clk);
        #1;
        exp_cnt = 16'hFFFF;
        total++; if (bus.redirect_cnt !== exp_cnt) begin bad++; $display("FAIL sat_reach got=%h exp=%h", bus.redirect_cnt, exp_cnt); end
        @(negedge clk);
        total++; if (ctl !== 6'b111110) begin bad++; $display("FAIL sat_ctl got=%b exp=%b", ctl, 6'b111110); end
        next_cycle();
        total++; if (bus.redirect_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=%h", bus.redirect_cnt, 16'hFFFF); end
        bus.imem_stall = 1'b1;
        next_cycle();
        total++; if (ctl !== 6'b000011) begin bad++; $display("FAIL rh_hold_ctl got=%b exp=%b", ctl, 6'b000011); end
        rst = 1'b0;
        #1;
        total++; if (ctl !== 6'b000000) begin bad++; $display("FAIL rh_rst_ctl got=%b exp=%b", ctl, 6'b000000); end
        total++; if (bus.redirect_cnt !== 16'h0) begin bad++; $display("FAIL rh_rst_cnt got=%h exp=%h", bus.redirect_cnt, 16'h0); end
        next_cycle();
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        total++; if (ctl !== 6'b011000) begin bad++; $display("FAIL rh_norep_ctl got=%b exp=%b", ctl, 6'b011000); end
        next_cycle();
        @(negedge clk);
        total++; if (ctl !== 6'b011000) begin bad++; $display("FAIL rh_norep2_ctl got=%b exp=%b", ctl, 6'b011000); end
        total++; if (bus.redirect_cnt !== 16'h0) begin bad++; $display("FAIL rh_cnt got=%h exp=%h", bus.redirect_cnt, 16'h0); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_cnt = 16'h0;
        rst = 1'b0;
        set_idle();
        test_reset();
        test_redirect_imm();
        test_hold_replay();
        test_dmem_stall();
        test_load_use();
        test_saturate_and_reset_in_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
